// File: rtl/mu0_pkg.sv
// Shared types and constants for the MU0 fetch/execute controller.
package mu0_pkg;

  localparam int unsigned OP_W = 4;
  localparam int unsigned FS_W = 2;

  // Instruction opcodes (IR[15:12])
  localparam logic [OP_W-1:0] OP_LDA = 4'd0;
  localparam logic [OP_W-1:0] OP_STA = 4'd1;
  localparam logic [OP_W-1:0] OP_ADD = 4'd2;
  localparam logic [OP_W-1:0] OP_SUB = 4'd3;
  localparam logic [OP_W-1:0] OP_JMP = 4'd4;
  localparam logic [OP_W-1:0] OP_JGE = 4'd5;
  localparam logic [OP_W-1:0] OP_JNE = 4'd6;
  localparam logic [OP_W-1:0] OP_STP = 4'd7;

  // ALU function selects
  localparam logic [FS_W-1:0] FS_Y   = 2'b00;
  localparam logic [FS_W-1:0] FS_ADD = 2'b01;
  localparam logic [FS_W-1:0] FS_INC = 2'b10;
  localparam logic [FS_W-1:0] FS_SUB = 2'b11;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC  = 2'b01,
    HALT  = 2'b10
  } state_t;

  // Control vector presented to the datapath and memory
  typedef struct packed {
    logic            mem_req;
    logic            rnw;
    logic            addr_sel;
    logic            x_sel;
    logic            y_sel;
    logic [FS_W-1:0] alu_fs;
    logic            ir_ce;
    logic            pc_ce;
    logic            acc_ce;
    logic            acc_oe;
    logic            halted;
    logic            instr_done;
  } ctrl_out_t;

  // Opcodes LDA/STA/ADD/SUB touch memory during EXEC
  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return (op <= OP_SUB);
  endfunction

endpackage

// File: rtl/mu0_control_if.sv
// Controller <-> datapath/memory signal bundle.
interface mu0_control_if;
  import mu0_pkg::*;

  logic [OP_W-1:0] Opcode;
  logic            AccN;
  logic            AccZ;
  logic            MemAck;
  logic            MemReq;
  logic            RnW;
  logic            AddrSel;
  logic            XSel;
  logic            YSel;
  logic [FS_W-1:0] ALUfs;
  logic            IRce;
  logic            PCce;
  logic            ACCce;
  logic            AccOE;
  logic            Halted;
  logic            InstrDone;

  // Controller side
  modport master (
    input  Opcode, AccN, AccZ, MemAck,
    output MemReq, RnW, AddrSel, XSel, YSel, ALUfs,
           IRce, PCce, ACCce, AccOE, Halted, InstrDone
  );

  // Datapath / memory side
  modport slave (
    output Opcode, AccN, AccZ, MemAck,
    input  MemReq, RnW, AddrSel, XSel, YSel, ALUfs,
           IRce, PCce, ACCce, AccOE, Halted, InstrDone
  );
endinterface

// File: rtl/mu0_ctrl_decode.sv
// Combinational map from state, opcode, flags and MemAck to the control vector.
module mu0_ctrl_decode
  import mu0_pkg::*;
(
  input  state_t          i_state,
  input  logic [OP_W-1:0] i_opcode,
  input  logic            i_acc_n,
  input  logic            i_acc_z,
  input  logic            i_mem_ack,
  output ctrl_out_t       o_ctrl
);

  // Per-state / per-opcode output decode; enables on memory cycles wait for MemAck
  always_comb begin
    o_ctrl = '0;
    unique case (i_state)
      FETCH: begin
        o_ctrl.mem_req  = 1'b1;
        o_ctrl.rnw      = 1'b1;
        o_ctrl.addr_sel = 1'b0;
        o_ctrl.x_sel    = 1'b1;
        o_ctrl.alu_fs   = FS_INC;
        o_ctrl.ir_ce    = i_mem_ack;
        o_ctrl.pc_ce    = i_mem_ack;
      end
      EXEC: begin
        unique case (i_opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            o_ctrl.mem_req    = 1'b1;
            o_ctrl.rnw        = 1'b1;
            o_ctrl.addr_sel   = 1'b1;
            o_ctrl.y_sel      = 1'b0;
            o_ctrl.acc_ce     = i_mem_ack;
            o_ctrl.instr_done = i_mem_ack;
            if (i_opcode == OP_LDA) begin
              o_ctrl.alu_fs = FS_Y;
            end else if (i_opcode == OP_ADD) begin
              o_ctrl.alu_fs = FS_ADD;
            end else begin
              o_ctrl.alu_fs = FS_SUB;
            end
          end
          OP_STA: begin
            o_ctrl.mem_req    = 1'b1;
            o_ctrl.rnw        = 1'b0;
            o_ctrl.addr_sel   = 1'b1;
            o_ctrl.acc_oe     = 1'b1;
            o_ctrl.instr_done = i_mem_ack;
          end
          OP_JMP, OP_JGE, OP_JNE: begin
            o_ctrl.y_sel      = 1'b1;
            o_ctrl.alu_fs     = FS_Y;
            o_ctrl.instr_done = 1'b1;
            if (i_opcode == OP_JMP) begin
              o_ctrl.pc_ce = 1'b1;
            end else if (i_opcode == OP_JGE) begin
              o_ctrl.pc_ce = ~i_acc_n;
            end else begin
              o_ctrl.pc_ce = ~i_acc_z;
            end
          end
          default: begin
            // STP and reserved opcodes: one idle cycle, no enables
            o_ctrl.instr_done = 1'b1;
          end
        endcase
      end
      HALT: begin
        o_ctrl.halted = 1'b1;
      end
      default: begin
        o_ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/mu0_control.sv
// MU0 fetch/execute control FSM with req/ack memory handshake.
module mu0_control
  import mu0_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset,
  mu0_control_if.master       ctrl
);

  state_t    r_state;
  state_t    w_next_state;
  ctrl_out_t w_dec;
  ctrl_out_t w_out;

  mu0_ctrl_decode u_decode (
    .i_state   (r_state),
    .i_opcode  (ctrl.Opcode),
    .i_acc_n   (ctrl.AccN),
    .i_acc_z   (ctrl.AccZ),
    .i_mem_ack (ctrl.MemAck),
    .o_ctrl    (w_dec)
  );

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: memory cycles advance on MemAck, others after one cycle
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      FETCH: begin
        if (ctrl.MemAck) begin
          w_next_state = EXEC;
        end
      end
      EXEC: begin
        if (!is_mem_op(ctrl.Opcode) || ctrl.MemAck) begin
          w_next_state = (ctrl.Opcode == OP_STP) ? HALT : FETCH;
        end
      end
      HALT: begin
        w_next_state = HALT;
      end
      default: begin
        w_next_state = FETCH;
      end
    endcase
  end

  // Outputs: force all controls low while Reset is asserted so an aborted access never strobes
  always_comb begin
    w_out = w_dec;
    if (Reset) begin
      w_out = '0;
    end
  end

  assign ctrl.MemReq    = w_out.mem_req;
  assign ctrl.RnW       = w_out.rnw;
  assign ctrl.AddrSel   = w_out.addr_sel;
  assign ctrl.XSel      = w_out.x_sel;
  assign ctrl.YSel      = w_out.y_sel;
  assign ctrl.ALUfs     = w_out.alu_fs;
  assign ctrl.IRce      = w_out.ir_ce;
  assign ctrl.PCce      = w_out.pc_ce;
  assign ctrl.ACCce     = w_out.acc_ce;
  assign ctrl.AccOE     = w_out.acc_oe;
  assign ctrl.Halted    = w_out.halted;
  assign ctrl.InstrDone = w_out.instr_done;

endmodule

// File: tb/tb_mu0_control.sv
// Self-checking bench for mu0_control; expected control vectors queued per driven cycle.
module tb_mu0_control;
  import mu0_pkg::*;

  typedef struct packed {
    logic       rst;
    logic [3:0] op;
    logic       n;
    logic       z;
    logic       ack;
  } stim_t;

  logic Clk;
  logic Reset;
  int   n_checks;
  int   n_pass;
  ctrl_out_t sb[$];

  mu0_control_if bus();

  mu0_control dut (
    .Clk   (Clk),
    .Reset (Reset),
    .ctrl  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic stim_t st(input logic rst, input logic [3:0] op,
                               input logic n, input logic z, input logic ack);
    stim_t s;
    s.rst = rst; s.op = op; s.n = n; s.z = z; s.ack = ack;
    return s;
  endfunction

  // Field order: MemReq RnW AddrSel XSel YSel ALUfs IRce PCce ACCce AccOE Halted InstrDone
  function automatic ctrl_out_t mk(input logic mr, input logic rnw, input logic as,
                                   input logic xs, input logic ys, input logic [1:0] fs,
                                   input logic ir, input logic pc, input logic acc,
                                   input logic oe, input logic hl, input logic dn);
    ctrl_out_t c;
    c.mem_req = mr; c.rnw = rnw; c.addr_sel = as; c.x_sel = xs; c.y_sel = ys;
    c.alu_fs = fs; c.ir_ce = ir; c.pc_ce = pc; c.acc_ce = acc; c.acc_oe = oe;
    c.halted = hl; c.instr_done = dn;
    return c;
  endfunction

  function automatic ctrl_out_t get_obs();
    return mk(bus.MemReq, bus.RnW, bus.AddrSel, bus.XSel, bus.YSel, bus.ALUfs,
              bus.IRce, bus.PCce, bus.ACCce, bus.AccOE, bus.Halted, bus.InstrDone);
  endfunction

  // Expected vectors written straight from the opcode table
  localparam ctrl_out_t E_ZERO  = 13'b0;
  ctrl_out_t e_fetch1, e_fetch0, e_lda1, e_add0, e_add1, e_sta1;
  ctrl_out_t e_jmp_t, e_jmp_n, e_stp, e_halt, e_nop;

  // Apply inputs mid-low-phase and queue what the outputs must be
  task automatic drive(input stim_t s, input ctrl_out_t exp_v);
    @(negedge Clk);
    Reset      = s.rst;
    bus.Opcode = s.op;
    bus.AccN   = s.n;
    bus.AccZ   = s.z;
    bus.MemAck = s.ack;
    sb.push_back(exp_v);
    #1;
  endtask

  task automatic test_reset();
    stim_t s[$]; ctrl_out_t e[$]; ctrl_out_t obs, exp_v;
    s.push_back(st(1, 4'd0, 0, 0, 1)); e.push_back(E_ZERO);
    s.push_back(st(1, 4'd2, 1, 1, 1)); e.push_back(E_ZERO);
    s.push_back(st(0, 4'd0, 0, 0, 1)); e.push_back(e_fetch1);
    s.push_back(st(0, 4'd0, 0, 0, 1)); e.push_back(e_lda1);
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i], e[i]);
      obs = get_obs(); exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) $display("FAIL reset[%0d]: got %b want %b", i, obs, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_add_wait();
    stim_t s[$]; ctrl_out_t e[$]; ctrl_out_t obs, exp_v;
    s.push_back(st(0, 4'd2, 0, 0, 0)); e.push_back(e_fetch0);
    s.push_back(st(0, 4'd2, 0, 0, 1)); e.push_back(e_fetch1);
    s.push_back(st(0, 4'd2, 0, 0, 0)); e.push_back(e_add0);
    s.push_back(st(0, 4'd2, 0, 0, 0)); e.push_back(e_add0);
    s.push_back(st(0, 4'd2, 0, 0, 1)); e.push_back(e_add1);
    s.push_back(st(0, 4'd2, 0, 0, 1)); e.push_back(e_fetch1);
    s.push_back(st(0, 4'd0, 0, 0, 1)); e.push_back(e_lda1);
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i], e[i]);
      obs = get_obs(); exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) $display("FAIL add_wait[%0d]: got %b want %b", i, obs, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_sta();
    stim_t s[$]; ctrl_out_t e[$]; ctrl_out_t obs, exp_v;
    s.push_back(st(0, 4'd1, 0, 0, 1)); e.push_back(e_fetch1);
    s.push_back(st(0, 4'd1, 0, 0, 1)); e.push_back(e_sta1);
    s.push_back(st(0, 4'd1, 0, 0, 1)); e.push_back(e_fetch1);
    s.push_back(st(0, 4'd0, 0, 0, 1)); e.push_back(e_lda1);
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i], e[i]);
      obs = get_obs(); exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) $display("FAIL sta[%0d]: got %b want %b", i, obs, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_jumps();
    stim_t s[$]; ctrl_out_t e[$]; ctrl_out_t obs, exp_v;
    s.push_back(st(0, 4'd5, 1, 0, 1)); e.push_back(e_fetch1);
    s.push_back(st(0, 4'd5, 1, 0, 1)); e.push_back(e_jmp_n);
    s.push_back(st(0, 4'd5, 0, 1, 1)); e.push_back(e_fetch1);
    s.push_back(st(0, 4'd5, 0, 1, 1)); e.push_back(e_jmp_t);
    s.push_back(st(0, 4'd6, 0, 1, 1)); e.push_back(e_fetch1);
    s.push_back(st(0, 4'd6, 0, 1, 1)); e.push_back(e_jmp_n);
    s.push_back(st(0, 4'd6, 1, 0, 1)); e.push_back(e_fetch1);
    s.push_back(st(0, 4'd6, 1, 0, 1)); e.push_back(e_jmp_t);
    s.push_back(st(0, 4'd4, 1, 1, 1)); e.push_back(e_fetch1);
    s.push_back(st(0, 4'd4, 1, 1, 0)); e.push_back(e_jmp_t);
    s.push_back(st(0, 4'd4, 0, 0, 0)); e.push_back(e_fetch0);
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i], e[i]);
      obs = get_obs(); exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) $display("FAIL jumps[%0d]: got %b want %b", i, obs, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_stp_nop();
    stim_t s[$]; ctrl_out_t e[$]; ctrl_out_t obs, exp_v;
    s.push_back(st(0, 4'd7, 0, 0, 1)); e.push_back(e_fetch1);
    s.push_back(st(0, 4'd7, 0, 0, 1)); e.push_back(e_stp);
    for (int k = 0; k < 10; k++) begin
      s.push_back(st(0, 4'(k), k[0], k[1], k[0])); e.push_back(e_halt);
    end
    s.push_back(st(1, 4'hA, 0, 0, 1)); e.push_back(E_ZERO);
    s.push_back(st(0, 4'hA, 0, 0, 1)); e.push_back(e_fetch1);
    s.push_back(st(0, 4'hA, 0, 0, 1)); e.push_back(e_nop);
    s.push_back(st(0, 4'hA, 0, 0, 1)); e.push_back(e_fetch1);
    s.push_back(st(0, 4'hF, 0, 0, 0)); e.push_back(e_nop);
    s.push_back(st(0, 4'hF, 0, 0, 0)); e.push_back(e_fetch0);
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i], e[i]);
      obs = get_obs(); exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) $display("FAIL stp_nop[%0d]: got %b want %b", i, obs, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_fetch();
    stim_t s[$]; ctrl_out_t e[$]; ctrl_out_t obs, exp_v;
    s.push_back(st(0, 4'd1, 0, 0, 0)); e.push_back(e_fetch0);
    s.push_back(st(1, 4'd1, 0, 0, 0)); e.push_back(E_ZERO);
    s.push_back(st(1, 4'd1, 0, 0, 1)); e.push_back(E_ZERO);
    s.push_back(st(0, 4'd1, 0, 0, 1)); e.push_back(e_fetch1);
    s.push_back(st(0, 4'd1, 0, 0, 1)); e.push_back(e_sta1);
    s.push_back(st(0, 4'd1, 0, 0, 1)); e.push_back(e_fetch1);
    s.push_back(st(0, 4'd1, 0, 0, 0)); e.push_back(mk(1,0,1,0,0,2'b00,0,0,0,1,0,0));
    s.push_back(st(1, 4'd1, 0, 0, 0)); e.push_back(E_ZERO);
    s.push_back(st(0, 4'd1, 0, 0, 0)); e.push_back(e_fetch0);
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i], e[i]);
      obs = get_obs(); exp_v = sb.pop_front(); n_checks++;
      if (obs !== exp_v) $display("FAIL reset_mid[%0d]: got %b want %b", i, obs, exp_v);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    Reset      = 1'b1;
    bus.Opcode = 4'd0;
    bus.AccN   = 1'b0;
    bus.AccZ   = 1'b0;
    bus.MemAck = 1'b1;

    e_fetch1 = mk(1,1,0,1,0,2'b10,1,1,0,0,0,0);
    e_fetch0 = mk(1,1,0,1,0,2'b10,0,0,0,0,0,0);
    e_lda1   = mk(1,1,1,0,0,2'b00,0,0,1,0,0,1);
    e_add0   = mk(1,1,1,0,0,2'b01,0,0,0,0,0,0);
    e_add1   = mk(1,1,1,0,0,2'b01,0,0,1,0,0,1);
    e_sta1   = mk(1,0,1,0,0,2'b00,0,0,0,1,0,1);
    e_jmp_t  = mk(0,0,0,0,1,2'b00,0,1,0,0,0,1);
    e_jmp_n  = mk(0,0,0,0,1,2'b00,0,0,0,0,0,1);
    e_stp    = mk(0,0,0,0,0,2'b00,0,0,0,0,0,1);
    e_halt   = mk(0,0,0,0,0,2'b00,0,0,0,0,1,0);
    e_nop    = mk(0,0,0,0,0,2'b00,0,0,0,0,0,1);

    test_reset();
    test_add_wait();
    test_sta();
    test_jumps();
    test_stp_nop();
    test_reset_mid_fetch();

    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mu0_control.md
Name: mu0_control

Overview:
- Fetch/execute control FSM for the MU0 12-bit-address, 16-bit-instruction datapath.
- Drives the clock enables of the ACC, PC and IR registers (12/16-bit enabled registers with async reset), plus the datapath mux selects, the ALU function and the memory request.
- Adds a req/ack memory handshake so wait-state memories are supported; with MemAck tied high it gives the classic 2-cycle instruction timing.
- Sits between the IR opcode field, the ACC flags and the memory interface.

Parameters:
- OP_W, 4, opcode width (IR[15:12])
- FS_W, 2, ALU function-select width

Ports:
- Clk  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-high reset
- Opcode  input  4  IR[15:12], valid in EXEC
- AccN  input  1  ACC[15], negative flag
- AccZ  input  1  ACC==0, zero flag
- MemAck  input  1  memory completes the current access this cycle
- MemReq  output  1  memory access request
- RnW  output  1  1=read, 0=write (meaningful only when MemReq=1)
- AddrSel  output  1  0=PC, 1=IR[11:0] drives the address bus
- XSel  output  1  ALU X operand: 0=ACC, 1=PC
- YSel  output  1  ALU Y operand: 0=memory data, 1=IR[11:0] zero-extended
- ALUfs  output  2  00=Y, 01=X+Y, 10=X+1, 11=X-Y
- IRce  output  1  IR load enable
- PCce  output  1  PC load enable
- ACCce  output  1  ACC load enable
- AccOE  output  1  ACC drives the memory write bus
- Halted  output  1  processor stopped
- InstrDone  output  1  one-cycle pulse when an EXEC completes

Behaviour:
- States: FETCH, EXEC, HALT. Reset leaves the FSM in FETCH.
- While Reset=1, every output is 0, including MemReq and all enables. Reset asserted mid-access aborts the access immediately, with no write enable pulse.
- Outputs are combinational from state, Opcode, flags and MemAck. Every register enable that accompanies a memory access is gated by MemAck.
- FETCH:
  - MemReq=1, RnW=1, AddrSel=0, XSel=1, ALUfs=10.
  - IRce=PCce=MemAck.
  - MemAck=1 -> EXEC; MemAck=0 -> stay in FETCH with outputs held.
- EXEC, by Opcode:
  - 0 LDA: MemReq=1, RnW=1, AddrSel=1, YSel=0, ALUfs=00, ACCce=MemAck.
  - 1 STA: MemReq=1, RnW=0, AddrSel=1, AccOE=1. No register enables.
  - 2 ADD: as LDA but XSel=0, ALUfs=01.
  - 3 SUB: as LDA but XSel=0, ALUfs=11.
  - 4 JMP: MemReq=0, YSel=1, ALUfs=00, PCce=1.
  - 5 JGE: as JMP but PCce=~AccN.
  - 6 JNE: as JMP but PCce=~AccZ.
  - 7 STP: no enables; next state HALT.
  - 8-15: reserved, executed as a 1-cycle NOP (no enables, no MemReq).
- EXEC exit:
  - Memory opcodes (0-3) leave EXEC only on MemAck=1 and hold outputs until then.
  - Non-memory opcodes leave EXEC after one cycle.
  - On exit, InstrDone=1 for that cycle and next state is FETCH (HALT for STP).
- Flags are sampled combinationally from the current ACC during the EXEC cycle.
- HALT: Halted=1, all other outputs 0. HALT is absorbing; only Reset leaves it.
- MemAck is ignored when MemReq=0. MemAck held high continuously gives FETCH/EXEC alternation with 2 cycles per instruction.
- PC wraps 0xFFF -> 0x000 in the datapath; no control action is required.

Decomposition:
- mu0_pkg:
  - opcode constants OP_LDA..OP_STP
  - state encoding FETCH=2'b00, EXEC=2'b01, HALT=2'b10
  - ALU function constants FS_Y, FS_ADD, FS_INC, FS_SUB
- One natural sub-module: mu0_ctrl_decode, purely combinational, mapping (state, Opcode, AccN, AccZ, MemAck) to the output vector.
- mu0_control holds the state register and the next-state logic, and instantiates mu0_ctrl_decode.

Test Plan:
- Reset with MemAck=1:
  - Reset high -> all outputs 0.
  - Release -> cycle 1 FETCH: MemReq=1, RnW=1, AddrSel=0, ALUfs=10, IRce=PCce=1.
  - Cycle 2 EXEC.
- ADD with wait states: Opcode=2, MemAck low for 2 EXEC cycles then high -> ACCce=0, 0, 1; XSel=0, ALUfs=01 held throughout; InstrDone pulses only on the third cycle.
- STA: Opcode=1, MemAck=1 -> RnW=0, AddrSel=1, AccOE=1, ACCce=PCce=0; next state FETCH.
- Conditional jumps:
  - JGE with AccN=1 -> PCce=0; with AccN=0 -> PCce=1, ALUfs=00, YSel=1.
  - JNE with AccZ=1 -> PCce=0.
  - All complete in one EXEC cycle with MemReq=0.
- STP then reserved opcode:
  - Opcode=7 -> HALT; Halted=1 persists for 10 cycles, MemReq=0.
  - After Reset, Opcode=0xA -> 1-cycle NOP with no enables, then FETCH.
- Reset mid-FETCH: assert Reset while MemReq=1 and MemAck=0 -> outputs 0 in the same cycle; after release, FETCH restarts.
